// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: keeps one memory read in flight and queues fetched
// {instr, pc} pairs in a small FIFO, flushing everything on a fetch-stream redirect.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    output logic [1:0]  fsmState
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_FREE  = CW'(DEPTH - 1);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]    state;
    logic [15:0]   fetchPc;
    logic [15:0]   reqAddr;
    logic [CW-1:0] count;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [15:0]   instrMem [DEPTH];
    logic [15:0]   pcMem    [DEPTH];
    logic          pop;
    logic          push;

    // Handshakes: a word is consumed on an edge where instr_valid && instr_ready
    // and no redirect; a memory word is accepted on an edge where mem_req && mem_ack.
    assign pop  = instr_valid && instr_ready && !redirect;
    assign push = (state == WAIT) && mem_ack && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            count   <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
        end else begin
            if (redirect) begin
                count   <= '0;
                wrPtr   <= '0;
                rdPtr   <= '0;
                fetchPc <= redirect_pc;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) wrPtr <= wrPtr + 1'b1;
                if (pop)  rdPtr <= rdPtr + 1'b1;
            end

            case (state)
                FETCH: begin
                    // Issue only if the returning word is guaranteed a free slot.
                    if (!redirect && ((count != FULL_COUNT) || pop)) begin
                        state   <= WAIT;
                        reqAddr <= fetchPc;
                        fetchPc <= fetchPc + 16'd4;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state <= mem_ack ? FETCH : DISCARD;
                    end else if (mem_ack) begin
                        if ((count != LAST_FREE) || pop) begin
                            reqAddr <= fetchPc;
                            fetchPc <= fetchPc + 16'd4;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DISCARD: begin
                    // The stale request must still complete before a new one can go out.
                    if (mem_ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= mem_rdata;
            pcMem[wrPtr]    <= reqAddr;
        end
    end

    assign mem_req     = (state == WAIT) || (state == DISCARD);
    assign mem_addr    = reqAddr;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? instrMem[rdPtr] : 16'h0000;
    assign instr_pc    = instr_valid ? pcMem[rdPtr] : 16'h0000;
    assign fsmState    = state;
endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: per-cycle vector table, scoreboarded fetch streams,
// redirect/discard corner cases and a RESET_PC wrap instance.
module tb_instr_prefetch;
    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_ready;
    logic        force_ack;
    int          lat;
    int          wait_cnt;

    logic        mem_req, mem_ack, instr_valid;
    logic [15:0] mem_addr, mem_rdata, instr, instr_pc;
    logic [1:0]  fsm_state;

    logic        mem_req1, mem_ack1, instr_valid1;
    logic [15:0] mem_addr1, mem_rdata1, instr1, instr_pc1;
    logic [1:0]  fsm_state1;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        redir;
        logic [15:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
    } vec_t;
    vec_t vecs[14];

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    instr_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fsmState(fsm_state)
    );

    instr_prefetch #(.DEPTH(4), .RESET_PC(16'hFFF8)) u_wrap (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack1), .mem_rdata(mem_rdata1),
        .instr_valid(instr_valid1), .instr(instr1), .instr_pc(instr_pc1),
        .instr_ready(instr_ready), .fsmState(fsm_state1)
    );

    // Memory models: u_dut sees a configurable latency, u_wrap is zero-wait.
    assign mem_ack    = mem_req && (wait_cnt >= lat);
    assign mem_rdata  = mem_ack ? word_at(mem_addr) : 16'hDEAD;
    assign mem_ack1   = mem_req1 || force_ack;
    assign mem_rdata1 = word_at(mem_addr1);

    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int latency);
        lat         = latency;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Compares the head against the scoreboard when it will be consumed on the next edge.
    task automatic sb_mon();
        logic [31:0] e;
        if (instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {instr, instr_pc}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", {instr, instr_pc}, e);
            end
        end
    endtask

    task automatic expect_pcs(input logic [15:0] start, input int n);
        logic [15:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({word_at(pc), pc});
            pc = pc + 16'd4;
        end
    endtask

    task automatic drain(input int budget, input logic random_ready, output int iters);
        iters = 0;
        while (exp_q.size() != 0 && iters < budget) begin
            tick();
            iters++;
            instr_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            sb_mon();
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        instr_ready = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n;
        n = 0;
        while (fsm_state != s && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", 32'(fsm_state), 32'(s));
    endtask

    initial begin
        int iters;

        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0000};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000C, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0004};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h0008};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008};
        vecs[9]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0104, 1'b1, 16'h0100};
        vecs[12] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = 1'b0;
        force_ack   = 1'b0;
        lat         = 0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", {instr, instr_pc}, 0);
        check("rst_state", 32'(fsm_state), 32'(S_FETCH));
        reset = 1'b0;

        // Per-cycle vectors: fill-to-full, resume, redirect on a full FIFO, redirect with ack.
        for (int i = 0; i < 14; i++) begin
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            instr_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(vecs[i].e_pc));
            check($sformatf("v%0d_instr", i), 32'(instr),
                  vecs[i].e_valid ? 32'(word_at(vecs[i].e_pc)) : 32'h0);
        end
        redirect    = 1'b0;
        instr_ready = 1'b0;

        // Zero-wait streaming: one instruction per cycle after the two-cycle startup.
        instr_ready = 1'b1;
        do_reset(0);
        expect_pcs(16'h0000, 12);
        drain(100, 1'b0, iters);
        check("stream_rate", iters, 13);

        // Random consumer against a slower memory.
        do_reset(int'($urandom_range(1, 2)));
        expect_pcs(16'h0000, 20);
        drain(400, 1'b1, iters);

        // Redirect during a slow request: stale word dropped, refetch from target.
        do_reset(3);
        tick();
        check("b_wait", 32'(fsm_state), 32'(S_WAIT));
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("b_discard", 32'(fsm_state), 32'(S_DISCARD));
        check("b_req_held", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
        wait_state(S_FETCH, 20);
        check("b_no_stale", 32'(instr_valid), 0);
        tick();
        check("b_new_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0100});
        expect_pcs(16'h0100, 3);
        drain(60, 1'b0, iters);

        // Two redirects inside one DISCARD: the last target wins.
        do_reset(3);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect_pc = 16'h0300;
        tick();
        redirect = 1'b0;
        check("c_still_discard", 32'(fsm_state), 32'(S_DISCARD));
        wait_state(S_FETCH, 20);
        tick();
        check("c_new_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0300});
        expect_pcs(16'h0300, 2);
        drain(60, 1'b0, iters);

        // Wrapping instance: FFF8, FFFC, 0000, 0004.
        instr_ready = 1'b1;
        do_reset(0);
        tick();
        check("w_first_addr", {15'd0, mem_req1, mem_addr1}, {15'd0, 1'b1, 16'hFFF8});
        check("w_first_valid", 32'(instr_valid1), 0);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] epc;
            epc = 16'hFFF8 + 16'(4 * i);
            tick();
            check($sformatf("w_pc%0d", i), {instr1, instr_pc1}, {word_at(epc), epc});
        end

        // Reset mid-request, with acks forced during reset and the first FETCH cycle.
        check("w_req_before_rst", 32'(mem_req1), 1);
        force_ack = 1'b1;
        reset     = 1'b1;
        #1;
        check("w_rst_req", 32'(mem_req1), 0);
        check("w_rst_valid", 32'(instr_valid1), 0);
        check("w_rst_instr", {instr1, instr_pc1}, 0);
        tick();
        reset = 1'b0;
        tick();
        check("w_restart_addr", {15'd0, mem_req1, mem_addr1}, {15'd0, 1'b1, 16'hFFF8});
        check("w_ack_ignored", 32'(instr_valid1), 0);
        force_ack = 1'b0;
        tick();
        check("w_restart_pc", {instr1, instr_pc1}, {word_at(16'hFFF8), 16'hFFF8});
        instr_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter: DEPTH, default 4, number of prefetch buffer entries (power of two, >= 2).
REQ-002 Parameter: RESET_PC, default 16'h0000, first fetch byte address after reset.
REQ-003 Port: clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset of all state.
REQ-005 Port: redirect  input  1  core requests a fetch-stream change (taken branch, BX, BL).
REQ-006 Port: redirect_pc  input  16  new fetch byte address, sampled when redirect=1.
REQ-007 Port: mem_req  output  1  instruction-memory read request.
REQ-008 Port: mem_addr  output  16  byte address of the current request.
REQ-009 Port: mem_ack  input  1  memory returns mem_rdata for the held request this cycle.
REQ-010 Port: mem_rdata  input  16  instruction word, valid only when mem_ack=1.
REQ-011 Port: instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 Port: instr  output  16  instruction at the buffer head.
REQ-013 Port: instr_pc  output  16  byte address of instr.
REQ-014 Port: instr_ready  input  1  core consumes the head this cycle.

Function
REQ-015 The block SHALL hold fetch_pc (16 bits), a DEPTH-entry FIFO of {instr, pc} pairs, an occupancy count, and a 3-state FSM: FETCH, WAIT, DISCARD.
REQ-016 mem_req SHALL be 1 exactly in WAIT and DISCARD; mem_addr SHALL equal the address latched at request issue and stay stable until the mem_ack cycle.
REQ-017 At most one request SHALL be outstanding; mem_ack SHALL be ignored in FETCH.
REQ-018 FETCH -> WAIT when count + (pop this cycle ? -1 : 0) < DEPTH; the request address latches fetch_pc; fetch_pc increments by 4.
REQ-019 WAIT with mem_ack=1 and no redirect: push {mem_rdata, mem_addr}; if space remains after the push and pop, stay in WAIT with the next address (back-to-back, one instruction per cycle); else go to FETCH.
REQ-020 WAIT with mem_ack=0 and no redirect: hold state and request.
REQ-021 fetch_pc increments SHALL wrap modulo 2^16 (16'hFFFC + 4 = 16'h0000).
REQ-022 instr_valid SHALL equal (count != 0); instr/instr_pc SHALL be the FIFO head combinationally.
REQ-023 A pop SHALL occur when instr_valid=1 and instr_ready=1 and redirect=0; instr_ready with an empty FIFO has no effect.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; the request-issue rule guarantees a push never overflows the FIFO.
REQ-025 redirect=1 SHALL, on that edge: empty the FIFO (count=0), load fetch_pc with redirect_pc, and ignore any same-cycle pop.
REQ-026 redirect in FETCH: go to FETCH. Redirect in WAIT with mem_ack=1: discard mem_rdata, go to FETCH. Redirect in WAIT with mem_ack=0: go to DISCARD.
REQ-027 DISCARD SHALL keep the old request asserted; on mem_ack, discard mem_rdata and go to FETCH; never push from DISCARD.
REQ-028 A redirect received in DISCARD SHALL only reload fetch_pc (last redirect wins); state stays DISCARD until mem_ack.
REQ-029 The first instruction after a redirect SHALL be fetched from redirect_pc; no pre-redirect instruction SHALL ever appear on instr after the redirect edge.

Reset
REQ-030 While reset=1 (asynchronously): state=FETCH, fetch_pc=RESET_PC, count=0, FIFO pointers=0, mem_req=0, instr_valid=0.
REQ-031 instr and instr_pc SHALL be 16'h0000 during reset; FIFO storage need not be cleared.
REQ-032 Reset asserted mid-request SHALL abandon the request; a subsequent mem_ack during reset or in FETCH SHALL be ignored.
REQ-033 First rising edge with reset=0 SHALL take FETCH -> WAIT with mem_addr=RESET_PC.

Verification
REQ-034 Zero-wait memory (mem_ack=mem_req), instr_ready=1 -> instr_pc sequence 0,4,8,... one per cycle after 2-cycle startup; instr matches memory contents.
REQ-035 instr_ready=0, zero-wait memory -> exactly DEPTH (4) entries buffered, mem_req drops to 0, instr_pc at head stays 0; raising instr_ready resumes fetch at 16'h0010.
REQ-036 Memory 3-cycle latency, redirect to 16'h0100 in WAIT cycle 1 -> DISCARD, stale word dropped on ack, next mem_addr=16'h0100, first instr_pc after redirect=16'h0100.
REQ-037 Two redirects (16'h0200 then 16'h0300) during one DISCARD -> next request at 16'h0300; redirect+instr_ready same cycle with full FIFO -> count=0, no pop counted.
REQ-038 RESET_PC=16'hFFF8, zero-wait memory -> instr_pc sequence FFF8, FFFC, 0000, 0004; reset asserted while mem_req=1 -> mem_req=0 and instr_valid=0 immediately, fetch restarts at FFF8.
